pwm_multi_dac: RTL and testbench

PWM_MULTI_DAC -- requirements
Module: pwm_multi_dac

---
 rtl/pwm_multi_dac.sv | 152 +++++++++++++++
 tb/tb_pwm_multi_dac.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_dac.sv
// ---------------------------------------------------------------------------
// pwm_multi_dac
//
// Multi-channel PWM DAC with double-buffered duty words.
//
// A single WIDTH-bit period counter is shared by all channels. Each channel
// has an active duty register, which drives the comparator, and a shadow
// register, which the sample handshake loads. All shadows share one
// shadow_full flag. The shadow set moves into the active set only at the
// period boundary (the last count of a period). Every duty change therefore
// lands on a period edge and reaches all channels in the same cycle.
//
// When a boundary arrives with no new sample pending, the previous duties
// repeat. This is an underrun.
//
// Build option:
//   PWM_MULTI_DAC_UNDERRUN_EN -- when defined, underrun_count counts the
//   boundaries that found shadow_full clear, saturating at 16'hFFFF. When
//   undefined, underrun_count is tied to zero. The port list is the same in
//   both builds.
//
// Reset is synchronous and active-high. It wins over every other input in
// the same cycle.
// ---------------------------------------------------------------------------
module pwm_multi_dac #(
  parameter int CHANNELS = 2,  // 1..8
  parameter int WIDTH    = 10  // 2..16, period = 2**WIDTH cycles
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [CHANNELS*WIDTH-1:0] sample_data,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic [15:0]               underrun_count
);

  localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic                shadow_full;
  logic                boundary;
  logic                accept;
  logic                swap;
  logic [CHANNELS-1:0] pwm_next;

  // The boundary is the last count of a running period.
  assign boundary = en && (cnt == CNT_LAST);

  // The shadow set moves into the active set only at a boundary that has a
  // pending sample.
  assign swap = boundary && shadow_full;

  // Ready depends only on registered state. On a swap cycle shadow_full is
  // still 1, so a new sample cannot collide with the copy. The new sample is
  // taken one cycle later.
  assign sample_ready = ~shadow_full;
  assign accept       = sample_valid && sample_ready;

  // Period counter: runs while enabled, wraps naturally, and parks at 0
  // while disabled so that re-enabling starts a fresh period.
  always_ff @(posedge clk) begin
    // NOTE: registered state always uses non-blocking assignments. Every
    // always_ff then reads pre-edge values, whatever order the blocks
    // evaluate in.
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Shadow registers and their shared full flag: the handshake loads them,
  // and a swap drains them.
  always_ff @(posedge clk) begin
    // NOTE: the duty arrays are ordinary flops, not RAM. Clearing them here
    // guarantees that the outputs stay low after reset until a real sample
    // arrives.
    if (rst) begin
      shadow_full <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
      end
    end else if (accept) begin
      shadow_full <= 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= sample_data[i*WIDTH +: WIDTH];
      end
    end else if (swap) begin
      shadow_full <= 1'b0;
    end
  end

  // Active duty registers: all channels change together, and only on a
  // swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= '0;
      end
    end else if (swap) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  // Per-channel comparator: a channel is high while the count is below its
  // duty. This gives exactly D high cycles per period.
  always_comb begin
    // NOTE: the whole vector gets a default before any conditional write.
    // That way no bit can hold its value and infer a latch.
    pwm_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_next[i] = en && (cnt < active[i]);
    end
  end

  // Output register: one cycle of latency on the waveforms and on the
  // period marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= pwm_next;
      period_start <= boundary;
    end
  end

`ifdef PWM_MULTI_DAC_UNDERRUN_EN
  // Underrun counter: a boundary that finds no pending sample counts once.
  // The counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count <= '0;
    end else if (boundary && !shadow_full && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`else
  // Underrun tracking is compiled out. The port reads a constant zero.
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_pwm_multi_dac.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_dac
//
// Bench for pwm_multi_dac with WIDTH=4 and CHANNELS=2.
//
// A behavioural reference model steps alongside the DUT. Each cycle it
// pushes the expected {pwm_out, period_start, sample_ready, underrun_count}
// into a queue. That entry is popped and compared once the DUT outputs have
// settled after the clock edge.
//
// Directed scenarios add aggregate checks on top of the per-cycle
// comparison: high-cycle counts, pulse spacing, and handshake timing.
// ---------------------------------------------------------------------------
module tb_pwm_multi_dac;

  localparam int N = 2;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sample_valid;
  logic         sample_ready;
  logic [N*W-1:0] sample_data;
  logic [N-1:0] pwm_out;
  logic         period_start;
  logic [15:0]  underrun_count;

  pwm_multi_dac #(.CHANNELS(N), .WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_data    (sample_data),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  // Drive values held between cycles.
  logic         d_rst   = 1'b1;
  logic         d_en    = 1'b0;
  logic         d_valid = 1'b0;
  logic [N*W-1:0] d_data = '0;

  // Reference model state.
  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_act [N];
  logic [W-1:0] m_sh  [N];
  logic         m_full = 1'b0;
  logic [N-1:0] m_pwm  = '0;
  logic         m_ps   = 1'b0;
  logic [15:0]  m_ur   = '0;

  logic [19:0]  exp_q [$];
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Advance the model by one clock edge, using the inputs driven this cycle.
  task automatic model_step();
    logic bnd;
    logic rdy;
    rdy = !m_full;
    if (d_rst) begin
      m_cnt  = '0;
      m_full = 1'b0;
      m_pwm  = '0;
      m_ps   = 1'b0;
      m_ur   = '0;
      for (int i = 0; i < N; i++) begin
        m_act[i] = '0;
        m_sh[i]  = '0;
      end
    end else begin
      bnd = d_en && (m_cnt == 4'hF);
      for (int i = 0; i < N; i++) m_pwm[i] = d_en && (m_cnt < m_act[i]);
      m_ps = bnd;
      if (bnd && m_full) begin
        for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
        m_full = 1'b0;
      end
`ifdef PWM_MULTI_DAC_UNDERRUN_EN
      if (bnd && rdy && m_ur != 16'hFFFF) m_ur = m_ur + 16'd1;
`endif
      if (d_valid && rdy) begin
        for (int i = 0; i < N; i++) m_sh[i] = d_data[i*W +: W];
        m_full = 1'b1;
      end
      m_cnt = d_en ? m_cnt + 4'd1 : 4'd0;
    end
  endtask

  // One clock: drive the inputs, queue the expected outputs, then compare
  // after the edge.
  task automatic step();
    logic [19:0] e;
    @(negedge clk);
    rst          = d_rst;
    en           = d_en;
    sample_valid = d_valid;
    sample_data  = d_data;
    model_step();
    exp_q.push_back({m_pwm, m_ps, ~m_full, m_ur});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cycle", {12'd0, pwm_out, period_start, sample_ready, underrun_count}, {12'd0, e});
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_en = 1'b0; d_valid = 1'b0; d_data = '0;
    step();
    step();
    d_rst = 1'b0;
  endtask

  // Step until a period_start pulse shows, or the cycle budget runs out.
  // Returns the number of steps taken and the high cycles seen per channel.
  task automatic wait_ps(output int n, output int h0, output int h1);
    n = 0; h0 = 0; h1 = 0;
    do begin
      step();
      n++;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
    end while (!period_start && n < 64);
    check("ps_seen", {31'd0, period_start}, 32'd1);
  endtask

  task automatic run_count(input int n, output int h0, output int h1, output int ps);
    h0 = 0; h1 = 0; ps = 0;
    for (int k = 0; k < n; k++) begin
      step();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      ps += int'(period_start);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h0, h1, ps, a0, a1, k;
    for (int i = 0; i < N; i++) begin
      m_act[i] = '0;
      m_sh[i]  = '0;
    end
    rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_data = '0;

    // Reset state.
    do_reset();
    check("rst_pwm",   {30'd0, pwm_out}, 32'd0);
    check("rst_ready", {31'd0, sample_ready}, 32'd1);
    check("rst_ps",    {31'd0, period_start}, 32'd0);
    check("rst_ur",    {16'd0, underrun_count}, 32'd0);
    check("rst_cnt",   {28'd0, dut.cnt}, 32'd0);

    // Duties ch0=3, ch1=12.
    d_en = 1'b1; d_valid = 1'b1; d_data = {4'd12, 4'd3};
    step();
    check("acc_ready", {31'd0, sample_ready}, 32'd0);
    d_valid = 1'b0;
    wait_ps(n, h0, h1);
    check("first_ps_lat", n, 15);
    check("first_h0", h0, 0);
    check("first_h1", h1, 0);
    run_count(16, h0, h1, ps);
    check("d3_h0", h0, 3);
    check("d12_h1", h1, 12);
    run_count(32, h0, h1, ps);
    check("ps_per_32", ps, 2);

    // Extreme duties: ch0=0, ch1=15.
    do_reset();
    d_en = 1'b1; d_valid = 1'b1; d_data = {4'd15, 4'd0};
    step();
    d_valid = 1'b0;
    wait_ps(n, h0, h1);
    run_count(32, h0, h1, ps);
    check("d0_h0", h0, 0);
    check("d15_h1", h1, 30);

    // Back-pressure: sample B waits while sample A is pending.
    do_reset();
    d_en = 1'b1; d_valid = 1'b1; d_data = {4'd5, 4'd9};
    step();
    d_data = {4'd14, 4'd2};
    k = 0;
    do begin
      step();
      k++;
      if (!sample_ready) a0 = k;
    end while (!sample_ready && k < 64);
    check("bp_ready_lat", k, 15);
    check("bp_ready_at_ps", {31'd0, period_start}, 32'd1);
    step();
    check("bp_b_taken", {31'd0, sample_ready}, 32'd0);
    d_valid = 1'b0;
    h0 = int'(pwm_out[0]); h1 = int'(pwm_out[1]);
    run_count(15, a0, a1, ps);
    check("bp_a_h0", h0 + a0, 9);
    check("bp_a_h1", h1 + a1, 5);
    run_count(16, h0, h1, ps);
    check("bp_b_h0", h0, 2);
    check("bp_b_h1", h1, 14);

    // Underrun: three periods with no new sample.
    do_reset();
    d_en = 1'b1; d_valid = 1'b1; d_data = {4'd7, 4'd4};
    step();
    d_valid = 1'b0;
    wait_ps(n, h0, h1);
    check("ur_start", {16'd0, underrun_count}, 32'd0);
    run_count(48, h0, h1, ps);
    check("ur_h0", h0, 12);
    check("ur_h1", h1, 21);
    check("ur_ps", ps, 3);
`ifdef PWM_MULTI_DAC_UNDERRUN_EN
    check("ur_count", {16'd0, underrun_count}, 32'd3);
`else
    check("ur_count", {16'd0, underrun_count}, 32'd0);
`endif

    // Reset mid-period while a sample is pending.
    do_reset();
    d_en = 1'b1; d_valid = 1'b1; d_data = {4'd14, 4'd13};
    step();
    d_valid = 1'b0;
    wait_ps(n, h0, h1);
    d_valid = 1'b1; d_data = {4'd2, 4'd2};
    for (int i = 0; i < 5; i++) step();
    check("mid_full", {31'd0, sample_ready}, 32'd0);
    check("mid_pwm_hi", {30'd0, pwm_out}, 32'd3);
    d_rst = 1'b1;
    step();
    d_rst = 1'b0; d_valid = 1'b0;
    check("mr_pwm",   {30'd0, pwm_out}, 32'd0);
    check("mr_ready", {31'd0, sample_ready}, 32'd1);
    check("mr_cnt",   {28'd0, dut.cnt}, 32'd0);
    run_count(40, h0, h1, ps);
    check("mr_h0", h0, 0);
    check("mr_h1", h1, 0);

    // Enable drops for 5 cycles mid-period.
    do_reset();
    d_en = 1'b1; d_valid = 1'b1; d_data = {4'd6, 4'd10};
    step();
    d_valid = 1'b0;
    wait_ps(n, h0, h1);
    for (int i = 0; i < 5; i++) step();
    d_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("en_off_pwm", {30'd0, pwm_out}, 32'd0);
      check("en_off_cnt", {28'd0, dut.cnt}, 32'd0);
    end
    d_en = 1'b1;
    wait_ps(n, h0, h1);
    check("reen_lat", n, 16);
    check("reen_h0", h0, 10);
    check("reen_h1", h1, 6);

    check("q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
